// File: rtl/xtx_moment_acc.sv
// rtl/xtx_moment_acc.sv - streaming n / sum(x) / sum(x^2) moment accumulator
module xtx_moment_acc #(
    parameter int XW    = 6,
    parameter int MAX_N = 16384
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          x_valid,
    input  logic [XW-1:0] x,
    input  logic          last,
    output logic          busy,
    output logic          done,
    output logic          sig_valid,
    output logic [20:0]   sig0,
    output logic [19:0]   sig1,
    output logic [31:0]   sig2,
    output logic          ovf
);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t            state;
    logic [20:0]       cnt;
    logic              s1_valid;
    logic [XW-1:0]     s1_x;
    logic [2*XW-1:0]   s1_sq;
    logic [2*XW-1:0]   x_ext;
    logic              take;
    logic              at_max;

    assign x_ext  = {{XW{1'b0}}, x};
    // start on the same edge wins over a sample, so it is never taken
    assign take   = (state == ACC) && x_valid && !start;
    // cnt tracks stage-1 acceptances, one edge ahead of sig0
    assign at_max = (cnt == 21'(MAX_N));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sig_valid <= 1'b0;
            sig0      <= '0;
            sig1      <= '0;
            sig2      <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_sq     <= '0;
        end else if (start) begin
            state     <= ACC;
            busy      <= 1'b1;
            done      <= 1'b0;
            sig_valid <= 1'b0;
            sig0      <= '0;
            sig1      <= '0;
            sig2      <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            s1_valid  <= 1'b0;
        end else begin
            done     <= 1'b0;
            s1_valid <= take && !at_max;
            if (take && !at_max) begin
                s1_x  <= x;
                s1_sq <= x_ext * x_ext;
                cnt   <= cnt + 21'd1;
            end
            if (take && at_max)
                ovf <= 1'b1;
            if (s1_valid) begin
                sig0 <= sig0 + 21'd1;
                sig1 <= sig1 + 20'(s1_x);
                sig2 <= sig2 + 32'(s1_sq);
            end
            case (state)
                ACC: begin
                    if (take && last)
                        state <= DRAIN;
                end
                DRAIN: begin
                    state     <= DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    sig_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xtx_moment_acc.sv
// tb/tb_xtx_moment_acc.sv - directed vector bench for xtx_moment_acc
module tb_xtx_moment_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        x_valid = 1'b0;
    logic [5:0]  x = '0;
    logic        last = 1'b0;

    logic        a_busy, a_done, a_sv, a_ovf;
    logic [20:0] a_s0;
    logic [19:0] a_s1;
    logic [31:0] a_s2;
    logic        b_busy, b_done, b_sv, b_ovf;
    logic [20:0] b_s0;
    logic [19:0] b_s1;
    logic [31:0] b_s2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    xtx_moment_acc #(.XW(6), .MAX_N(16384)) dut_a (
        .clk(clk), .rst(rst), .start(start), .x_valid(x_valid), .x(x), .last(last),
        .busy(a_busy), .done(a_done), .sig_valid(a_sv),
        .sig0(a_s0), .sig1(a_s1), .sig2(a_s2), .ovf(a_ovf)
    );

    xtx_moment_acc #(.XW(6), .MAX_N(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .x_valid(x_valid), .x(x), .last(last),
        .busy(b_busy), .done(b_done), .sig_valid(b_sv),
        .sig0(b_s0), .sig1(b_s1), .sig2(b_s2), .ovf(b_ovf)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic        xv;
        logic [5:0]  x;
        logic        last;
        logic        busy;
        logic        done;
        logic        sv;
        logic [20:0] s0;
        logic [19:0] s1;
        logic [31:0] s2;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic xv, input logic [5:0] xx,
                       input logic l, input logic b, input logic d, input logic sv,
                       input int s0, input int s1, input int s2, input logic o);
        vec_t v;
        v.rst = r; v.start = s; v.xv = xv; v.x = xx; v.last = l;
        v.busy = b; v.done = d; v.sv = sv;
        v.s0 = 21'(s0); v.s1 = 20'(s1); v.s2 = 32'(s2); v.ovf = o;
        vecs.push_back(v);
    endtask

    task automatic drive_step(input logic r, input logic s, input logic xv,
                              input logic [5:0] xx, input logic l);
        @(negedge clk);
        rst = r; start = s; x_valid = xv; x = xx; last = l;
        @(posedge clk);
        #1;
    endtask

    // packed as {busy, done, sig_valid, ovf, sig0, sig1, sig2}
    task automatic chk(input string name, input logic [76:0] act, input logic [76:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got b/d/v/o=%b%b%b%b n=%0d sx=%0d sxx=%0d, want b/d/v/o=%b%b%b%b n=%0d sx=%0d sxx=%0d",
                     name, act[76], act[75], act[74], act[73], act[72:52], act[51:32], act[31:0],
                     exp[76], exp[75], exp[74], exp[73], exp[72:52], exp[51:32], exp[31:0]);
        end
    endtask

    function automatic logic [76:0] pk(input logic b, input logic d, input logic v, input logic o,
                                       input logic [20:0] s0, input logic [19:0] s1,
                                       input logic [31:0] s2);
        return {b, d, v, o, s0, s1, s2};
    endfunction

    initial begin
        // reset
        add(1,0,0, 0,0,  0,0,0,  0, 0,   0, 0);
        // x = 1,2,3 with last on 3
        add(0,1,0, 0,0,  1,0,0,  0, 0,   0, 0);
        add(0,0,1, 1,0,  1,0,0,  0, 0,   0, 0);
        add(0,0,1, 2,0,  1,0,0,  1, 1,   1, 0);
        add(0,0,1, 3,1,  1,0,0,  2, 3,   5, 0);
        add(0,0,0, 0,0,  0,1,1,  3, 6,  14, 0);
        add(0,0,0, 0,0,  0,0,1,  3, 6,  14, 0);
        // gapped stream 5,_,_,7,_,2(last)
        add(0,1,0, 0,0,  1,0,0,  0, 0,   0, 0);
        add(0,0,1, 5,0,  1,0,0,  0, 0,   0, 0);
        add(0,0,0, 0,1,  1,0,0,  1, 5,  25, 0);
        add(0,0,0, 0,0,  1,0,0,  1, 5,  25, 0);
        add(0,0,1, 7,0,  1,0,0,  1, 5,  25, 0);
        add(0,0,0, 0,0,  1,0,0,  2,12,  74, 0);
        add(0,0,1, 2,1,  1,0,0,  2,12,  74, 0);
        add(0,0,0, 0,0,  0,1,1,  3,14,  78, 0);
        // restart mid-run, same-edge start+sample dropped
        add(0,1,0, 0,0,  1,0,0,  0, 0,   0, 0);
        add(0,0,1, 9,0,  1,0,0,  0, 0,   0, 0);
        add(0,0,1, 9,0,  1,0,0,  1, 9,  81, 0);
        add(0,1,1, 9,0,  1,0,0,  0, 0,   0, 0);
        add(0,0,1, 4,1,  1,0,0,  0, 0,   0, 0);
        add(0,0,0, 0,0,  0,1,1,  1, 4,  16, 0);
        // samples ignored in DONE, then rst during DRAIN
        add(0,0,1, 8,1,  0,0,1,  1, 4,  16, 0);
        add(0,1,0, 0,0,  1,0,0,  0, 0,   0, 0);
        add(0,0,1, 1,1,  1,0,0,  0, 0,   0, 0);
        add(1,0,0, 0,0,  0,0,0,  0, 0,   0, 0);
        add(0,0,0, 0,0,  0,0,0,  0, 0,   0, 0);
        add(0,0,1, 3,1,  0,0,0,  0, 0,   0, 0);
        // single sample x=63
        add(0,1,0, 0,0,  1,0,0,  0, 0,   0, 0);
        add(0,0,1,63,1,  1,0,0,  0, 0,   0, 0);
        add(0,0,0, 0,0,  0,1,1,  1,63,3969, 0);

        foreach (vecs[i]) begin
            drive_step(vecs[i].rst, vecs[i].start, vecs[i].xv, vecs[i].x, vecs[i].last);
            chk($sformatf("vec%0d", i),
                pk(a_busy, a_done, a_sv, a_ovf, a_s0, a_s1, a_s2),
                pk(vecs[i].busy, vecs[i].done, vecs[i].sv, vecs[i].ovf,
                   vecs[i].s0, vecs[i].s1, vecs[i].s2));
        end

        // hold for 20 idle cycles while x_valid toggles
        for (int i = 0; i < 20; i++) begin
            drive_step(0, 0, logic'(i % 2), 6'(i + 10), logic'(i % 3 == 0));
            chk($sformatf("hold%0d", i),
                pk(a_busy, a_done, a_sv, a_ovf, a_s0, a_s1, a_s2),
                pk(0, 0, 1, 0, 21'd1, 20'd63, 32'd3969));
        end

        // MAX_N=4 overflow on dut_b; dut_a takes all six
        drive_step(0, 1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            drive_step(0, 0, 1, 6'd1, logic'(i == 6));
            if (i == 4)
                chk("ovf_at_4", {31'd0, b_ovf}, 32'd0);
            if (i == 5)
                chk("ovf_at_5", {31'd0, b_ovf}, 32'd1);
        end
        chk("ovf_drain", pk(b_busy, b_done, b_sv, b_ovf, b_s0, b_s1, b_s2),
            pk(1, 0, 0, 1, 21'd4, 20'd4, 32'd4));
        drive_step(0, 0, 0, 0, 0);
        chk("ovf_done", pk(b_busy, b_done, b_sv, b_ovf, b_s0, b_s1, b_s2),
            pk(0, 1, 1, 1, 21'd4, 20'd4, 32'd4));
        chk("six_done", pk(a_busy, a_done, a_sv, a_ovf, a_s0, a_s1, a_s2),
            pk(0, 1, 1, 0, 21'd6, 20'd6, 32'd6));
        drive_step(0, 0, 0, 0, 0);
        chk("ovf_hold", pk(b_busy, b_done, b_sv, b_ovf, b_s0, b_s1, b_s2),
            pk(0, 0, 1, 1, 21'd4, 20'd4, 32'd4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xtx_moment_acc.md
# xtx_moment_acc

Streaming moment accumulator for the option-pricing least-squares path: it consumes one sample `x` per valid cycle and builds the three moments of the 2x2 normal matrix, n, Σx and Σx². It then presents them on the `sig0/sig1/sig2` interface that the matrix-inversion block samples. It is the producer (writer) side of that interface. Outputs are held stable after `done` until the next `start`.

## Interface
Parameters:
- `XW`, 6: width of unsigned sample `x`.
- `MAX_N`, 16384: maximum number of samples accepted per run. With the default `XW`, sums fit 20/32 bits without wrap.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse: clear accumulators, begin a run.
- `x_valid`  in  1  sample strobe; `x` is accepted on an edge where `x_valid`=1 in state ACC.
- `x`  in  XW  unsigned sample.
- `last`  in  1  qualifies with `x_valid`: the accepted sample is the final one of the run.
- `busy`  out  1  high in ACC and DRAIN.
- `done`  out  1  one-cycle pulse when the moments become final.
- `sig_valid`  out  1  level: `sig0..sig2` hold a completed run.
- `sig0`  out  21  n, count of accepted samples.
- `sig1`  out  20  Σx.
- `sig2`  out  32  Σx².
- `ovf`  out  1  sticky: a sample arrived after `MAX_N` were already accepted.

## Operation
- States:
  - IDLE (reset).
  - ACC.
  - DRAIN.
  - DONE.
- Transitions:
  - IDLE/DONE --`start`--> ACC. On the same edge: clear `sig0..sig2`, `ovf` and the pipeline valid bit; drop `sig_valid`.
  - ACC: accepts `x_valid` samples. On an accepted sample with `last`=1 --> DRAIN.
  - DRAIN --(next edge)--> DONE. The final pipeline stage lands on that edge; `done`=1 and `sig_valid`=1.
  - DONE: holds outputs; `done` drops after one cycle.
- Two-stage datapath:
  - Stage 1 registers `x` zero-extended and `x*x` (2·XW bits), plus a valid bit.
  - Stage 2 does `sig0 += 1`, `sig1 += x`, `sig2 += x²`.
  - All additions are unsigned and truncated to the port width. No saturation is required at the default parameters.
- Overflow: a sample with count already equal to `MAX_N` is not accumulated, and `ovf` is set. A `last` on such a sample still ends the run.
- `x_valid` in IDLE, DRAIN or DONE is ignored; `last` without `x_valid` is ignored.
- `start` in ACC or DRAIN restarts: clear everything, stay in or return to ACC. An in-flight stage-1 sample is discarded.
- `start` and `x_valid` on the same edge: the clear wins and the sample is dropped. The first sample is accepted one cycle after `start`.
- A run with zero samples is impossible; DONE is reached only via `last`.
- `rst` mid-run: all state is lost and the block returns to IDLE.

## Timing
- Reset values:
  - state IDLE.
  - `busy` 0, `done` 0, `sig_valid` 0.
  - `sig0`/`sig1`/`sig2` 0, `ovf` 0.
- Throughput: one sample per cycle, back-to-back `x_valid` is allowed with no stalls.
- Latency: sample accepted at edge k → included in `sig*` after edge k+1.
- Last sample at edge k:
  - DRAIN during k..k+1.
  - `done` high for exactly the cycle after edge k+1; `sig_valid` rises at edge k+1.
  - `busy` falls at edge k+1.
- Intermediate `sig*` values change during ACC. The consumer samples only when `sig_valid`=1.

## Test plan
- Reset, then `start`, then x=1,2,3 on consecutive cycles with `last` on 3 → `done` pulse 2 edges after the last sample; `sig0`=3, `sig1`=6, `sig2`=14; `sig_valid`=1; `ovf`=0.
- Single sample x=63 with `last` → `sig0`=1, `sig1`=63, `sig2`=3969; outputs held unchanged for 20 idle cycles while `x_valid` toggles.
- Gapped stream x=5,_,_,7,_,2(`last`) → 3, 14, 78; `busy` high throughout the gaps.
- `start` asserted mid-run after x=9,9, then x=4(`last`) → 1, 4, 16. Same-edge `start`+`x_valid` drops that sample.
- `MAX_N`=4 override: 6 samples of x=1, `last` on the 6th → `sig0`=4, `sig1`=4, `sig2`=4, `ovf`=1, `done` pulses.
- `rst` asserted during DRAIN → next cycle all outputs 0, state IDLE, no `done`.
